ball_controller: RTL and testbench

- Downstream partner of the collision stage.
- Consumes its registered wall/paddle flags, miss pulse and 2-bit scorer code.
- Owns ball position and direction, both players' scores, the serve delay and the game-over condition.
- Feeds ball x/y back to the collision stage and to the renderer.

---
 rtl/ball_controller.sv | 199 +++++++++++++++++++
 tb/tb_ball_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ball_controller.sv
// ball_controller
// Owns the ball position and direction, both players' scores, the serve
// hold-off and the game-over condition. Consumes the collision stage's
// registered wall/paddle flags, miss pulse and scorer code. It feeds the
// ball position back to the collision stage and to the renderer.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   tick       one-cycle pulse per video frame
//   coll_L/R   left/right paddle hit
//   coll_T/B   top/bottom wall hit
//   miss       ball passed a paddle
//   score      scorer code: 2 = player 1 scores, 1 = player 0 scores, 0/3 = none
//   x, y       ball top-left pixel
//   score_0/1  player points (left/right)
//   serving    high while the ball is held at centre
//   game_over  high once either score reaches WIN_SCORE
module ball_controller #(
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9,
    parameter int X_START      = 316,
    parameter int Y_START      = 236
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       coll_L,
    input  logic       coll_R,
    input  logic       coll_T,
    input  logic       coll_B,
    input  logic       miss,
    input  logic [1:0] score,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [3:0] score_0,
    output logic [3:0] score_1,
    output logic       serving,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    localparam logic [9:0]         X_START_V  = 10'(X_START);
    localparam logic [8:0]         Y_START_V  = 9'(Y_START);
    localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
    localparam logic signed [10:0] SPEED_S    = 11'(SPEED);
    localparam logic signed [10:0] X_MIN      = 11'sd32;
    localparam logic signed [10:0] X_MAX      = 11'sd600;
    localparam logic signed [10:0] Y_MIN      = 11'sd8;
    localparam logic signed [10:0] Y_MAX      = 11'sd464;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [3:0]  score_0_q, score_0_d;
    logic [3:0]  score_1_q, score_1_d;
    logic        serving_q, serving_d;
    logic        game_over_q, game_over_d;
    logic        dx_q, dx_d;          // 1 = moving right (+1), 0 = left (-1)
    logic        dy_q, dy_d;          // 1 = moving down (+1), 0 = up (-1)
    logic [7:0]  cnt_q, cnt_d;

    logic signed [10:0] x_sum;
    logic signed [10:0] y_sum;
    logic [3:0]         new_score;
    logic               scored;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        score_0_d   = score_0_q;
        score_1_d   = score_1_q;
        serving_d   = serving_q;
        game_over_d = game_over_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        cnt_d       = cnt_q;
        x_sum       = '0;
        y_sum       = '0;
        new_score   = '0;
        scored      = 1'b0;

        case (state_q)
            ST_SERVE: begin
                // Collision flags lag the position by a cycle, so nothing
                // but the frame tick is honoured while holding the serve.
                x_d = X_START_V;
                y_d = Y_START_V;
                if (tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        cnt_d     = '0;
                        state_d   = ST_PLAY;
                        serving_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            ST_PLAY: begin
                if (miss && score == 2'd2) begin
                    scored    = 1'b1;
                    new_score = (score_1_q < WIN) ? score_1_q + 4'd1 : score_1_q;
                    score_1_d = new_score;
                    dx_d      = 1'b0;   // serve toward player 0, who conceded
                end else if (miss && score == 2'd1) begin
                    scored    = 1'b1;
                    new_score = (score_0_q < WIN) ? score_0_q + 4'd1 : score_0_q;
                    score_0_d = new_score;
                    dx_d      = 1'b1;   // serve toward player 1, who conceded
                end

                if (scored) begin
                    x_d = X_START_V;
                    y_d = Y_START_V;
                    if (new_score == WIN) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                    end else begin
                        state_d   = ST_SERVE;
                        serving_d = 1'b1;
                    end
                end else begin
                    // Flips depend on the current direction so a flag that
                    // stays high for several cycles bounces only once.
                    if (coll_L && !dx_q) dx_d = 1'b1;
                    if (coll_R &&  dx_q) dx_d = 1'b0;
                    if (coll_T && !dy_q) dy_d = 1'b1;
                    if (coll_B &&  dy_q) dy_d = 1'b0;

                    if (tick) begin
                        // Step uses this cycle's updated direction.
                        x_sum = $signed({1'b0, x_q}) + (dx_d ? SPEED_S : -SPEED_S);
                        y_sum = $signed({2'b00, y_q}) + (dy_d ? SPEED_S : -SPEED_S);
                        if (x_sum < X_MIN)      x_d = X_MIN[9:0];
                        else if (x_sum > X_MAX) x_d = X_MAX[9:0];
                        else                    x_d = x_sum[9:0];
                        if (y_sum < Y_MIN)      y_d = Y_MIN[8:0];
                        else if (y_sum > Y_MAX) y_d = Y_MAX[8:0];
                        else                    y_d = y_sum[8:0];
                    end
                end
            end

            ST_OVER: begin
                x_d         = X_START_V;
                y_d         = Y_START_V;
                serving_d   = 1'b0;
                game_over_d = 1'b1;
            end

            default: begin
                state_d = ST_SERVE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SERVE;
            x_q         <= X_START_V;
            y_q         <= Y_START_V;
            score_0_q   <= '0;
            score_1_q   <= '0;
            serving_q   <= 1'b1;
            game_over_q <= 1'b0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            score_0_q   <= score_0_d;
            score_1_q   <= score_1_d;
            serving_q   <= serving_d;
            game_over_q <= game_over_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign score_0   = score_0_q;
    assign score_1   = score_1_q;
    assign serving   = serving_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_ball_controller.sv
// Testbench for ball_controller: directed stimulus pushes the expected output
// snapshot into a queue; a monitor pops and compares one cycle later.
module tb_ball_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, coll_L, coll_R, coll_T, coll_B, miss;
    logic [1:0] score;
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] score_0, score_1;
    logic       serving, game_over;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [3:0] s0;
        logic [3:0] s1;
        logic       serv;
        logic       over;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  e;
    int    checks = 0;
    int    errors = 0;

    ball_controller dut (
        .clk(clk), .reset(reset), .tick(tick),
        .coll_L(coll_L), .coll_R(coll_R), .coll_T(coll_T), .coll_B(coll_B),
        .miss(miss), .score(score),
        .x(x), .y(y), .score_0(score_0), .score_1(score_1),
        .serving(serving), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Monitor: every output update lands one cycle after its stimulus.
    always @(posedge clk) begin
        exp_t  w;
        exp_t  act;
        string nm;
        #1;
        if (exp_q.size() > 0) begin
            w   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = '{x, y, score_0, score_1, serving, game_over};
            checks++;
            if (act !== w) begin
                errors++;
                $display("FAIL %s: got x=%0d y=%0d s0=%0d s1=%0d serving=%b over=%b, expected x=%0d y=%0d s0=%0d s1=%0d serving=%b over=%b",
                         nm, act.x, act.y, act.s0, act.s1, act.serv, act.over,
                         w.x, w.y, w.s0, w.s1, w.serv, w.over);
            end else begin
                $display("ok   %s: x=%0d y=%0d s0=%0d s1=%0d serving=%b over=%b",
                         nm, act.x, act.y, act.s0, act.s1, act.serv, act.over);
            end
        end
    end

    task automatic drive(input logic t, input logic cl, input logic cr,
                         input logic ct, input logic cb, input logic m,
                         input logic [1:0] sc, input string nm);
        @(negedge clk);
        tick = t; coll_L = cl; coll_R = cr; coll_T = ct; coll_B = cb;
        miss = m; score = sc;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // 60 serve ticks; serving drops after the 60th. Optional junk cycles
    // present flags and a miss that must be ignored while serving.
    task automatic serve_round(input bit junk);
        for (int i = 0; i < 60; i++) begin
            if (i == 59) e.serv = 1'b0;
            drive(1, 0, 0, 0, 0, 0, 2'd0, "serve_tick");
            if (junk && i < 59) drive(0, 1, 1, 1, 1, 1, 2'd2, "serve_ignore");
        end
    endtask

    initial begin
        int ex, ey;
        exp_t act;
        reset = 1'b1;
        tick = 0; coll_L = 0; coll_R = 0; coll_T = 0; coll_B = 0; miss = 0;
        score = 2'd0;
        e = '{10'd316, 9'd236, 4'd0, 4'd0, 1'b1, 1'b0};
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'd0, "reset_state");

        // Serve with stale flags and miss presented between ticks.
        serve_round(1);

        // First PLAY tick: direction still right/down.
        e.x = 10'd318; e.y = 9'd238;
        drive(1, 0, 0, 0, 0, 0, 2'd0, "play_tick");

        // Miss with no scorer code is ignored.
        drive(0, 0, 0, 0, 0, 1, 2'd3, "miss_sc3");
        drive(0, 0, 0, 0, 0, 1, 2'd0, "miss_sc0");

        // coll_R held 5 cycles, ticks on cycles 0, 2, 4: flips once to left.
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) begin
                e.x = e.x - 10'd2;
                e.y = e.y + 9'd2;
            end
            drive((k % 2) == 0, 0, 1, 0, 0, 0, 2'd0, "coll_R_hold");
        end

        // Miss held 3 cycles with player 1 scoring: counted once.
        e.x = 10'd316; e.y = 9'd236; e.s1 = 4'd1; e.serv = 1'b1;
        repeat (3) drive(0, 0, 0, 0, 0, 1, 2'd2, "miss_p1");
        serve_round(0);
        e.x = 10'd314; e.y = 9'd238;
        drive(1, 0, 0, 0, 0, 0, 2'd0, "serve_left");

        // Turn upward, run into the top clamp, bounce off coll_T.
        drive(0, 0, 0, 0, 1, 0, 2'd0, "coll_B");
        for (int k = 0; k < 115; k++) begin
            e.x = e.x - 10'd2;
            e.y = e.y - 9'd2;
            drive(1, 0, 0, 0, 0, 0, 2'd0, "move_up");
        end
        e.x = 10'd82; e.y = 9'd8;
        drive(1, 0, 0, 0, 0, 0, 2'd0, "clamp_top");
        drive(0, 0, 0, 1, 0, 0, 2'd0, "coll_T");
        e.x = 10'd80; e.y = 9'd10;
        drive(1, 0, 0, 0, 0, 0, 2'd0, "bounce_down");

        // Down-left until both the left x clamp and bottom y clamp hold.
        for (int k = 1; k <= 228; k++) begin
            ex = 80 - 2 * k; if (ex < 32) ex = 32;
            ey = 10 + 2 * k; if (ey > 464) ey = 464;
            e.x = 10'(ex); e.y = 9'(ey);
            drive(1, 0, 0, 0, 0, 0, 2'd0, "move_down");
        end

        // Player 0 scores up to 8, then the winning point.
        for (int n = 1; n <= 8; n++) begin
            e.s0 = 4'(n); e.x = 10'd316; e.y = 9'd236; e.serv = 1'b1;
            drive(0, 0, 0, 0, 0, 1, 2'd1, "miss_p0");
            serve_round(0);
        end
        e.s0 = 4'd9; e.serv = 1'b0; e.over = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 2'd1, "game_over");
        drive(1, 1, 1, 1, 1, 1, 2'd1, "over_frozen");
        drive(1, 1, 1, 1, 1, 1, 2'd2, "over_frozen");
        drive(1, 0, 0, 0, 0, 0, 2'd0, "over_frozen");

        // Asynchronous reset takes effect without a clock edge.
        @(negedge clk);
        tick = 0; coll_L = 0; coll_R = 0; coll_T = 0; coll_B = 0; miss = 0;
        score = 2'd0;
        reset = 1'b1;
        #1;
        e = '{10'd316, 9'd236, 4'd0, 4'd0, 1'b1, 1'b0};
        act = '{x, y, score_0, score_1, serving, game_over};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL async_reset: got x=%0d y=%0d s0=%0d s1=%0d serving=%b over=%b",
                     act.x, act.y, act.s0, act.s1, act.serv, act.over);
        end else begin
            $display("ok   async_reset");
        end
        drive(1, 0, 0, 0, 0, 1, 2'd1, "reset_hold");
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'd0, "after_reset");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
